// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per cycle over WIDTH/CHUNK cycles,
// with valid/ready handshakes on both sides and registered result flags.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                     state_q, state_d;
  logic [N-1:0][CHUNK-1:0]    a_q, b_q, acc_q, res_full;
  logic                       carry_q;
  logic [IDXW-1:0]            idx_q;
  logic [CHUNK-1:0]           a_c, b_c;
  logic [CHUNK:0]             chunk_sum;
  logic                       msb_cin;
  logic                       last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign last      = (idx_q == IDXW'(N - 1));

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a variable unassigned (no inferred latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    a_c       = a_q[idx_q];
    b_c       = b_q[idx_q];
    chunk_sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ c.
    msb_cin   = chunk_sum[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    res_full  = acc_q;
    res_full[idx_q] = chunk_sum[CHUNK-1:0];
  end

  // NOTE: operand and working registers carry no reset; they are always
  // loaded on accept before anything reads them, so a reset discards them.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q     <= num1;
      b_q     <= op[0] ? ~num2 : num2;
      carry_q <= op[1] ? cin : op[0];
      idx_q   <= '0;
    end else if (state_q == CALC) begin
      acc_q[idx_q] <= chunk_sum[CHUNK-1:0];
      carry_q      <= chunk_sum[CHUNK];
      if (!last) idx_q <= idx_q + IDXW'(1);
    end
  end

  // Output registers change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
    end else if (state_q == CALC && last) begin
      result    <= res_full;
      carry_out <= chunk_sum[CHUNK];
      overflow  <= msb_cin ^ chunk_sum[CHUNK];
      zero      <= (res_full == '0);
      negative  <= res_full[N-1][CHUNK-1];
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (CHUNK = 1, 8, 32) share stimulus;
// table vectors, handshake/reset sequences and randomized ops against a model.
module tb_addsub_serial;

  typedef struct packed {
    logic [31:0] result;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin;
  logic [1:0]  op;
  logic [31:0] num1, num2;

  logic        ir [3];
  logic        ovd[3];
  logic        co [3];
  logic        ovf[3];
  logic        zr [3];
  logic        ng [3];
  logic [31:0] res[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    addsub_serial #(
      .WIDTH(32),
      .CHUNK(g == 0 ? 1 : (g == 1 ? 8 : 32))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .num1     (num1),
      .num2     (num2),
      .op       (op),
      .cin      (cin),
      .out_valid(ovd[g]),
      .out_ready(out_ready),
      .result   (res[g]),
      .carry_out(co[g]),
      .overflow (ovf[g]),
      .zero     (zr[g]),
      .negative (ng[g])
    );
  end

  function automatic int chunk_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 8 : 32);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: full-width add, carry into bit 31 from the low 31 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] o, input logic c);
    exp_t        e;
    logic [31:0] bb;
    logic        ci;
    logic [32:0] s;
    logic [31:0] low;
    bb  = o[0] ? ~b : b;
    ci  = o[1] ? c : o[0];
    s   = {1'b0, a} + {1'b0, bb} + 33'(ci);
    low = 32'(a[30:0]) + 32'(bb[30:0]) + 32'(ci);
    e.result = s[31:0];
    e.co     = s[32];
    e.ov     = low[31] ^ s[32];
    e.z      = (s[31:0] == 32'h0);
    e.n      = s[31];
    return e;
  endfunction

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues one op to all instances (all must be idle), checks latency and outputs.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic c, input exp_t e);
    int lat[3];
    lat = '{0, 0, 0};
    num1 = a; num2 = b; op = o; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    num1 = $urandom; num2 = $urandom; op = 2'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++)
        if (lat[g] == 0 && ovd[g]) lat[g] = k;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int g = 0; g < 3; g++) begin
      string s;
      s = $sformatf("%s c%0d", tag, chunk_of(g));
      check({s, " latency"},  64'(lat[g]), 64'(32 / chunk_of(g)));
      check({s, " result"},   64'(res[g]), 64'(e.result));
      check({s, " carry"},    64'(co[g]),  64'(e.co));
      check({s, " overflow"}, 64'(ovf[g]), 64'(e.ov));
      check({s, " zero"},     64'(zr[g]),  64'(e.z));
      check({s, " negative"}, 64'(ng[g]),  64'(e.n));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, 64'(ir[1]), 64'd1);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic        rc;

    //            a             b             op     cin    result        co    ov    z     n
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[1]  = '{32'h80000000, 32'h00000001, 2'b01, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{32'h00000005, 32'h00000005, 2'b01, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000000, 2'b10, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{32'h0000000A, 32'h00000003, 2'b11, 1'b0, '{32'h00000006, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{32'h00000003, 32'h00000004, 2'b00, 1'b0, '{32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{32'h00000003, 32'h00000004, 2'b01, 1'b0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[7]  = '{32'h80000000, 32'h80000000, 2'b00, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0}};
    vecs[8]  = '{32'h000000FF, 32'h00000000, 2'b10, 1'b1, '{32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{32'h00000001, 32'h00000001, 2'b00, 1'b1, '{32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{32'h00000000, 32'h00000000, 2'b01, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    num1 = '0; num2 = '0; op = 2'b00; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset in_ready",  64'(ir[1]),  64'd1);
    check("reset out_valid", 64'(ovd[1]), 64'd0);
    check("reset result",    64'(res[1]), 64'd0);
    check("reset carry",     64'(co[1]),  64'd0);
    check("reset overflow",  64'(ovf[1]), 64'd0);
    check("reset zero",      64'(zr[1]),  64'd1);
    check("reset negative",  64'(ng[1]),  64'd0);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].e);

    // Backpressure: hold result for 5 cycles while new operands are offered.
    num1 = 32'h10; num2 = 32'h20; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("hold entry valid", 64'(ovd[1]), 64'd1);
    held = res[1];
    check("hold entry result", 64'(held), 64'h30);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 2);
      num1 = 32'hDEAD0000; num2 = 32'h0000BEEF; op = 2'b11; cin = 1'b1;
      @(posedge clk); #1;
      check($sformatf("hold valid %0d", k),    64'(ovd[1]), 64'd1);
      check($sformatf("hold result %0d", k),   64'(res[1]), 64'h30);
      check($sformatf("hold in_ready %0d", k), 64'(ir[1]),  64'd0);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("consume in_ready",     64'(ir[1]),  64'd1);
    check("consume out_valid",    64'(ovd[1]), 64'd0);
    check("consume result kept",  64'(res[1]), 64'h30);
    reset_pulse();

    // Reset during the second CALC cycle, with in_valid competing.
    run_op("pre-reset", 32'h1, 32'h1, 2'b00, 1'b0, '{32'h2, 1'b0, 1'b0, 1'b0, 1'b0});
    num1 = 32'h12345678; num2 = 32'h11111111; op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("midcalc rst in_ready",  64'(ir[1]),  64'd1);
    check("midcalc rst out_valid", 64'(ovd[1]), 64'd0);
    check("midcalc rst result",    64'(res[1]), 64'd0);
    check("midcalc rst zero",      64'(zr[1]),  64'd1);
    run_op("post-reset add", 32'h3, 32'h4, 2'b00, 1'b0, '{32'h7, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; ro = 2'($urandom); rc = 1'($urandom);
      if (i % 4 == 0) rb = ra;
      if (i % 5 == 0) ra = 32'h7FFFFFFF + 32'(i);
      run_op($sformatf("rand%0d", i), ra, rb, ro, rc, model(ra, rb, ro, rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
